// File: rtl/fu_pkg.sv
// fu_pkg: shared ALU instruction type, issue-queue state encoding and ALU datapath widths
package fu_pkg;
  localparam int SIZE = 32;
  localparam int REG_NUM = 8;
  localparam int ALUOP_BITS = 3;
  localparam int RW = $clog2(REG_NUM);
  typedef struct packed {
    logic [ALUOP_BITS-1:0] ALUOp;
    logic [RW-1:0] src_reg1;
    logic [RW-1:0] src_reg2;
    logic use_imm;
    logic [SIZE-1:0] imm;
    logic [RW-1:0] dest_reg;
  } alu_instr_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} iq_state_t;
endpackage

// File: rtl/alu_issue_queue_if.sv
// alu_issue_queue_if: decoder-side valid/ready instruction channel plus FU_ALU issue/completion channel
//   master: the issue queue (takes in_* and Comp, drives in_ready, instruction fields, issue, fu_busy, issued_cnt)
//   slave : the surrounding decoder / FU_ALU side
interface alu_issue_queue_if;
  import fu_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [ALUOP_BITS-1:0] in_ALUOp;
  logic [RW-1:0] in_src_reg1;
  logic [RW-1:0] in_src_reg2;
  logic in_use_imm;
  logic [SIZE-1:0] in_imm;
  logic [RW-1:0] in_dest_reg;
  logic [ALUOP_BITS-1:0] ALUOp;
  logic [RW-1:0] src_reg1;
  logic [RW-1:0] src_reg2;
  logic use_imm;
  logic [SIZE-1:0] imm;
  logic [RW-1:0] dest_reg1;
  logic issue;
  logic Comp;
  logic fu_busy;
  logic [15:0] issued_cnt;
  modport master (
    input in_valid, in_ALUOp, in_src_reg1, in_src_reg2, in_use_imm, in_imm, in_dest_reg, Comp,
    output in_ready, ALUOp, src_reg1, src_reg2, use_imm, imm, dest_reg1, issue, fu_busy, issued_cnt
  );
  modport slave (
    output in_valid, in_ALUOp, in_src_reg1, in_src_reg2, in_use_imm, in_imm, in_dest_reg, Comp,
    input in_ready, ALUOp, src_reg1, src_reg2, use_imm, imm, dest_reg1, issue, fu_busy, issued_cnt
  );
endinterface

// File: rtl/alu_issue_queue_fifo.sv
// instr_fifo: synchronous FIFO of alu_instr_t; head is shown combinationally on dout
//   clk, rst: clock, sync active-high reset
//   push/din: write at tail; pop: advance head; count/full/empty: occupancy
module instr_fifo
  import fu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  alu_instr_t din,
  input  logic pop,
  output alu_instr_t dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic full,
  output logic empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  alu_instr_t mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[head];
  always_ff @(posedge clk)
    if (do_push) mem[tail] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop) head <= head + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: in-order issue stage feeding FU_ALU, one instruction in flight at a time
//   clk, rst: clock, sync active-high reset
//   bus (master): decoder push channel, registered instruction fields, issue pulse,
//                 Comp completion, fu_busy and wrapping 16-bit issued_cnt
module alu_issue_queue
  import fu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  alu_issue_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH+1);
  alu_instr_t in_instr, head, out_q;
  iq_state_t state, state_nxt;
  logic push, pop, full, empty;
  logic [CW-1:0] count;
  logic [15:0] cnt_q;
  assign in_instr = {bus.in_ALUOp, bus.in_src_reg1, bus.in_src_reg2, bus.in_use_imm, bus.in_imm, bus.in_dest_reg};
  assign bus.in_ready = count < CW'(DEPTH);
  assign push = bus.in_valid && !full;
  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(in_instr), .pop(pop),
    .dout(head), .count(count), .full(full), .empty(empty)
  );
  always_comb begin
    pop = state == IDLE && !empty;
    state_nxt = state == IDLE ? (pop ? ISSUE : IDLE) : (bus.Comp ? IDLE : WAIT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (pop) out_q <= head;
      if (state == ISSUE) cnt_q <= cnt_q + 1'b1;
    end
  end
  assign bus.issue = state == ISSUE;
  assign bus.fu_busy = state != IDLE;
  assign bus.issued_cnt = cnt_q;
  assign bus.ALUOp = out_q.ALUOp;
  assign bus.src_reg1 = out_q.src_reg1;
  assign bus.src_reg2 = out_q.src_reg2;
  assign bus.use_imm = out_q.use_imm;
  assign bus.imm = out_q.imm;
  assign bus.dest_reg1 = out_q.dest_reg;
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: randomized + directed checks of alu_issue_queue against a transaction-level model
module tb_alu_issue_queue;
  import fu_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 0;
  logic rst;
  logic in_valid, comp;
  alu_instr_t in_instr, out_instr;
  alu_issue_queue_if bus();
  alu_issue_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.in_valid = in_valid;
  assign bus.Comp = comp;
  assign bus.in_ALUOp = in_instr.ALUOp;
  assign bus.in_src_reg1 = in_instr.src_reg1;
  assign bus.in_src_reg2 = in_instr.src_reg2;
  assign bus.in_use_imm = in_instr.use_imm;
  assign bus.in_imm = in_instr.imm;
  assign bus.in_dest_reg = in_instr.dest_reg;
  assign out_instr = {bus.ALUOp, bus.src_reg1, bus.src_reg2, bus.use_imm, bus.imm, bus.dest_reg1};
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit armed = 0;
  alu_instr_t mq[$];
  bit m_busy;
  int m_issue_at = -1;
  alu_instr_t m_cur;
  logic [15:0] m_cnt;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  function automatic alu_instr_t rnd();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[$bits(alu_instr_t)-1:0];
  endfunction
  task automatic cycle();
    bit rdy, iss;
    @(negedge clk);
    rdy = mq.size() < DEPTH;
    iss = cyc == m_issue_at;
    if (armed) begin
      chk("issue", 64'(bus.issue), 64'(iss));
      chk("fu_busy", 64'(bus.fu_busy), 64'(m_busy));
      chk("in_ready", 64'(bus.in_ready), 64'(rdy));
      chk("issued_cnt", 64'(bus.issued_cnt), 64'(m_cnt));
      chk("instr", 64'(out_instr), 64'(m_cur));
    end
    if (rst) begin
      mq.delete();
      m_busy = 0;
      m_issue_at = -1;
      m_cur = '0;
      m_cnt = '0;
      armed = 1;
    end else if (armed) begin
      if (m_busy) begin
        if (comp) m_busy = 0;
      end else if (mq.size() > 0) begin
        m_cur = mq.pop_front();
        m_busy = 1;
        m_issue_at = cyc + 1;
      end
      if (iss) m_cnt++;
      if (in_valid && rdy) mq.push_back(in_instr);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic drain();
    int n = 0;
    in_valid = 0;
    comp = 1;
    while ((mq.size() > 0 || m_busy) && n < 60) begin
      cycle();
      n++;
    end
    if (n >= 60) chk("drain_timeout", 64'd1, 64'd0);
    comp = 0;
  endtask
  initial begin
    int n;
    in_valid = 0;
    comp = 0;
    in_instr = '0;
    rst = 1;
    repeat (2) cycle();
    rst = 0;
    in_instr = '0;
    in_instr.use_imm = 1'b1;
    in_instr.imm = 32'd10;
    in_instr.dest_reg = 3'd1;
    in_valid = 1;
    cycle();
    in_valid = 0;
    cycle();
    cycle();
    chk("first_issue_done", 64'(bus.issued_cnt), 64'd1);
    repeat (3) cycle();
    chk("first_busy", 64'(bus.fu_busy), 64'd1);
    chk("first_imm", 64'(bus.imm), 64'd10);
    chk("first_dest", 64'(bus.dest_reg1), 64'd1);
    comp = 1;
    cycle();
    comp = 0;
    in_valid = 1;
    repeat (7) begin
      in_instr = rnd();
      cycle();
    end
    in_valid = 0;
    chk("full_ready", 64'(bus.in_ready), 64'd0);
    n = 0;
    while ((mq.size() > 0 || m_busy) && n < 20) begin
      repeat (3) cycle();
      comp = 1;
      cycle();
      comp = 0;
      n++;
    end
    if (n >= 20) chk("fifo_order_timeout", 64'd1, 64'd0);
    in_valid = 1;
    in_instr = rnd();
    cycle();
    in_instr = rnd();
    cycle();
    in_valid = 0;
    repeat (12) begin
      comp = cyc == m_issue_at;
      cycle();
    end
    comp = 0;
    chk("fast_comp_cnt", 64'(bus.issued_cnt), 64'(m_cnt));
    drain();
    comp = 1;
    repeat (3) cycle();
    comp = 0;
    chk("idle_comp_busy", 64'(bus.fu_busy), 64'd0);
    in_valid = 1;
    n = 0;
    while (!(mq.size() == 3 && m_busy && cyc != m_issue_at) && n < 20) begin
      in_instr = rnd();
      cycle();
      n++;
    end
    if (n >= 20) chk("wait_setup_timeout", 64'd1, 64'd0);
    in_valid = 0;
    rst = 1;
    cycle();
    rst = 0;
    chk("rst_busy", 64'(bus.fu_busy), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_cnt", 64'(bus.issued_cnt), 64'd0);
    chk("rst_instr", 64'(out_instr), 64'd0);
    repeat (8) begin
      comp = 1'($urandom_range(0, 1));
      cycle();
    end
    comp = 0;
    chk("post_rst_cnt", 64'(bus.issued_cnt), 64'd0);
    repeat (3000) begin
      in_valid = 1'($urandom_range(0, 1));
      in_instr = rnd();
      comp = $urandom_range(0, 3) == 0;
      rst = $urandom_range(0, 299) == 0;
      cycle();
      rst = 0;
    end
    drain();
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    m_cnt = 16'hFFFE;
    n = 0;
    in_valid = 1;
    comp = 1;
    while (m_cnt != 16'h0 && n < 40) begin
      in_instr = rnd();
      cycle();
      n++;
    end
    if (n >= 40) chk("wrap_timeout", 64'd1, 64'd0);
    chk("wrap", 64'(bus.issued_cnt), 64'd0);
    repeat (6) cycle();
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
